// File: rtl/ovl_memory_model_if.sv
// ---------------------------------------------------------------------------
// ovl_memory_model_if
//
// Request/response bundle between a memory requester (master) and the
// ovl_memory_model responder (slave).
//
// Handshake: a request is taken on a rising clock edge only when
// ready & enable & (ren | wen) are all high. There is no back-pressure:
// while ready=0 or enable=0, requests are dropped. Read responses are
// marked by rvalid, a one-cycle pulse that the master must take in that
// cycle. rerr qualifies rvalid. werr is a one-cycle pulse that follows a
// rejected write.
//
// Signals (master view):
//   enable      out  request qualifier
//   start_addr  out  lowest legal address
//   end_addr    out  highest legal address (inclusive)
//   ren/raddr   out  read request and address
//   wen/waddr   out  write request and address
//   wdata       out  write data
//   ready       in   responder is taking requests
//   rvalid      in   read response pulse
//   rdata       in   read data (0 when rvalid=0 or rerr=1)
//   rerr        in   read error (out of range or uninitialised)
//   werr        in   write error pulse
// ---------------------------------------------------------------------------
interface ovl_memory_model_if #(
   parameter int data_width = 8,
   parameter int addr_width = 4
);
   logic                  enable;
   logic [addr_width-1:0] start_addr;
   logic [addr_width-1:0] end_addr;
   logic                  ren;
   logic [addr_width-1:0] raddr;
   logic                  wen;
   logic [addr_width-1:0] waddr;
   logic [data_width-1:0] wdata;
   logic                  ready;
   logic                  rvalid;
   logic [data_width-1:0] rdata;
   logic                  rerr;
   logic                  werr;

   modport master (
      output enable, start_addr, end_addr, ren, raddr, wen, waddr, wdata,
      input  ready, rvalid, rdata, rerr, werr
   );

   modport slave (
      input  enable, start_addr, end_addr, ren, raddr, wen, waddr, wdata,
      output ready, rvalid, rdata, rerr, werr
   );
endinterface

// File: rtl/ovl_memory_model.sv
// ---------------------------------------------------------------------------
// ovl_memory_model
//
// Synchronous memory responder with a fixed read latency. After reset the
// array is scrubbed one entry per cycle (SCRUB), then requests are served
// forever (IDLE). Each entry carries a valid bit so reads of entries never
// written since the scrub are flagged with rerr. Addresses outside
// [start_addr, end_addr] or beyond mem_size entries from start_addr are
// out of range: reads return rerr, writes return werr.
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   bus         slave modport of ovl_memory_model_if
//   dbg_idle_o  out  1 when the FSM is in IDLE, 0 while scrubbing
//
// Build option:
//   OVL_MEMORY_MODEL_ONE_WRITE_EN - when defined, an in-range write to an
//   entry that is already valid is rejected (mem unchanged, werr pulses).
// ---------------------------------------------------------------------------
module ovl_memory_model #(
   parameter int data_width   = 8,
   parameter int addr_width   = 4,
   parameter int mem_size     = 16,
   parameter int read_latency = 1
) (
   input  logic                clock,
   input  logic                reset,
   ovl_memory_model_if.slave   bus,
   output logic                dbg_idle_o
);

   typedef enum logic {ST_SCRUB = 1'b0, ST_IDLE = 1'b1} state_t;

   // One extra bit so mem_size == 2**addr_width is representable.
   localparam logic [addr_width:0]   MEM_SIZE_W = (addr_width+1)'(mem_size);
   localparam logic [addr_width-1:0] LAST_IDX   = addr_width'(mem_size - 1);

   state_t                state_q;
   logic [addr_width-1:0] cnt_q;
   logic                  ready_q;
   logic                  werr_q;

   // Read pipeline; stage 0 holds the result computed at acceptance.
   logic [read_latency-1:0] pv_q;
   logic [read_latency-1:0] pe_q;
   logic [data_width-1:0]   pd_q [read_latency];

   logic [data_width-1:0] mem_q [mem_size];
   logic [mem_size-1:0]   valid_q;

   logic                  rd_acc, wr_acc, rd_ok, wr_ok;
   logic [addr_width-1:0] ridx, widx;
   logic                  rd_err_d, werr_d;
   logic [data_width-1:0] rd_data_d;

   function automatic logic in_range(input logic [addr_width-1:0] a,
                                     input logic [addr_width-1:0] s,
                                     input logic [addr_width-1:0] e);
      logic [addr_width-1:0] diff;
      diff = a - s;
      return (a >= s) && (a <= e) && ({1'b0, diff} < MEM_SIZE_W);
   endfunction

   always_comb begin
      rd_acc    = ready_q & bus.enable & bus.ren;
      wr_acc    = ready_q & bus.enable & bus.wen;
      ridx      = bus.raddr - bus.start_addr;
      widx      = bus.waddr - bus.start_addr;
      // Reads see the array before this edge's write: read-before-write.
      rd_ok     = rd_acc & in_range(bus.raddr, bus.start_addr, bus.end_addr)
                  & valid_q[ridx];
      rd_data_d = rd_ok ? mem_q[ridx] : '0;
      rd_err_d  = rd_acc & ~rd_ok;
`ifdef OVL_MEMORY_MODEL_ONE_WRITE_EN
      wr_ok     = wr_acc & in_range(bus.waddr, bus.start_addr, bus.end_addr)
                  & ~valid_q[widx];
`else
      wr_ok     = wr_acc & in_range(bus.waddr, bus.start_addr, bus.end_addr);
`endif
      werr_d    = wr_acc & ~wr_ok;
   end

   // Control FSM, read pipeline and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_SCRUB;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         werr_q  <= 1'b0;
         pv_q    <= '0;
         pe_q    <= '0;
         for (int i = 0; i < read_latency; i++) pd_q[i] <= '0;
      end else begin
         case (state_q)
            ST_SCRUB: begin
               cnt_q <= cnt_q + addr_width'(1);
               if (cnt_q == LAST_IDX) begin
                  state_q <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            ST_IDLE: ;
            default: state_q <= ST_SCRUB;
         endcase
         werr_q  <= werr_d;
         pv_q[0] <= rd_acc;
         pe_q[0] <= rd_err_d;
         pd_q[0] <= rd_data_d;
         for (int i = 1; i < read_latency; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pd_q[i] <= pd_q[i-1];
         end
      end
   end

   // Storage: cleared entry by entry during SCRUB, written in IDLE.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == ST_SCRUB) begin
            mem_q[cnt_q]   <= '0;
            valid_q[cnt_q] <= 1'b0;
         end else if (wr_ok) begin
            mem_q[widx]   <= bus.wdata;
            valid_q[widx] <= 1'b1;
         end
      end
   end

   assign bus.ready  = ready_q;
   assign bus.rvalid = pv_q[read_latency-1];
   assign bus.rerr   = pe_q[read_latency-1];
   assign bus.rdata  = pd_q[read_latency-1];
   assign bus.werr   = werr_q;
   assign dbg_idle_o = (state_q == ST_IDLE);

endmodule
